// File: rtl/jtpang_ba_resp.sv
// 4-bank SDRAM request responder: arbitrates banks and programming port onto one 16-bit port.
// Optional periodic refresh slot enabled by defining JTPANG_BA_REFRESH_EN.
module jtpang_ba_resp #(
  parameter int AW             = 22,
  parameter int BURST          = 2,
  parameter int LAT            = 3,
  parameter int REFRESH_CYCLES = 384,
  parameter int REFRESH_LEN    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [3:0]    ba_rd,
  input  logic          ba_wr,
  input  logic [15:0]   ba0_din,
  input  logic [1:0]    ba0_din_m,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_dst,
  output logic [3:0]    ba_dok,
  output logic [3:0]    ba_rdy,
  output logic [15:0]   data_read,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_ba,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  input  logic          prog_we,
  input  logic          prog_rd,
  output logic          prog_ack,
  output logic          prog_dst,
  output logic          prog_dok,
  output logic          prog_rdy,
  output logic [AW+1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_din_m,
  input  logic [15:0]   mem_dout
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

`ifdef JTPANG_BA_REFRESH_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_REFRESH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE} state_t;
`endif

  state_t          r_state;
  state_t          w_state_nx;

  // Strobe vectors: bits 3:0 are the banks, bit 4 is the programming port.
  logic [4:0]      r_ack;
  logic [4:0]      r_dst;
  logic [4:0]      r_dok;
  logic [4:0]      r_rdy;
  logic [4:0]      r_own_oh;
  logic [1:0]      r_rr;
  logic [CW-1:0]   r_cnt;
  logic [AW+1:0]   r_mem_addr;
  logic            r_mem_rd;
  logic            r_mem_we;
  logic [15:0]     r_mem_din;
  logic [1:0]      r_mem_din_m;
  logic [15:0]     r_data_read;

  logic [LAT-1:0]  r_vld_p;
  logic [LAT-1:0]  r_fst_p;
  logic [LAT-1:0]  r_lst_p;

  logic            w_bank_hit;
  logic [1:0]      w_bank_sel;
  logic [1:0]      w_idx;
  logic [AW-1:0]   w_bank_addr;
  logic            w_gnt_rd;
  logic            w_gnt_wr;
  logic            w_gnt_prog;
  logic [4:0]      w_gnt_oh;
  logic [AW+1:0]   w_gnt_addr;
  logic [15:0]     w_gnt_din;
  logic [1:0]      w_gnt_mask;
  logic            w_burst_end;
  logic            w_drain_end;

  assign w_burst_end = (r_cnt == CW'(BURST - 1));
  assign w_drain_end = r_vld_p[LAT-1] & r_lst_p[LAT-1];

  // Round-robin search starting at the bank after the last one granted.
  always_comb begin
    w_bank_hit = 1'b0;
    w_bank_sel = r_rr;
    w_idx      = r_rr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_rr + 2'(i);
      if (!w_bank_hit && ba_rd[w_idx]) begin
        w_bank_hit = 1'b1;
        w_bank_sel = w_idx;
      end
    end
  end

  always_comb begin
    w_bank_addr = ba0_addr;
    case (w_bank_sel)
      2'd0:    w_bank_addr = ba0_addr;
      2'd1:    w_bank_addr = ba1_addr;
      2'd2:    w_bank_addr = ba2_addr;
      default: w_bank_addr = ba3_addr;
    endcase
  end

`ifdef JTPANG_BA_REFRESH_EN
  localparam int RCW = $clog2(REFRESH_CYCLES + 1);
  localparam int RLW = $clog2(REFRESH_LEN + 1);

  logic [RCW-1:0] r_ref_cnt;
  logic [RLW-1:0] r_ref_len;
  logic           r_ref_pend;
  logic           w_ref_done;

  assign w_ref_done = (r_ref_len == RLW'(REFRESH_LEN - 1));

  // Interval counter free-runs; a new pending request wins over a clear on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt  <= '0;
      r_ref_len  <= '0;
      r_ref_pend <= 1'b0;
    end else begin
      if (r_state == S_REFRESH) begin
        if (w_ref_done) begin
          r_ref_len  <= '0;
          r_ref_pend <= 1'b0;
        end else begin
          r_ref_len  <= r_ref_len + RLW'(1);
        end
      end
      if (r_ref_cnt == RCW'(REFRESH_CYCLES - 1)) begin
        r_ref_cnt  <= '0;
        r_ref_pend <= 1'b1;
      end else begin
        r_ref_cnt  <= r_ref_cnt + RCW'(1);
      end
    end
  end
`endif

  always_comb begin
    w_state_nx = r_state;
    w_gnt_rd   = 1'b0;
    w_gnt_wr   = 1'b0;
    w_gnt_prog = 1'b0;
    w_gnt_oh   = 5'b0;
    w_gnt_addr = {w_bank_sel, w_bank_addr};
    w_gnt_din  = ba0_din;
    w_gnt_mask = ba0_din_m;
    case (r_state)
      S_IDLE: begin
`ifdef JTPANG_BA_REFRESH_EN
        if (r_ref_pend) w_state_nx = S_REFRESH; else
`endif
        if (prog_we || prog_rd) begin
          w_gnt_prog = 1'b1;
          w_gnt_oh   = 5'b10000;
          w_gnt_addr = {prog_ba, prog_addr};
          w_gnt_din  = prog_data;
          w_gnt_mask = prog_mask;
          w_gnt_wr   = prog_we;
          w_gnt_rd   = !prog_we;
          w_state_nx = prog_we ? S_WRITE : S_ISSUE;
        end else if (w_bank_hit) begin
          w_gnt_oh   = {1'b0, 4'(4'b0001 << w_bank_sel)};
          w_gnt_wr   = (w_bank_sel == 2'd0) && ba_wr;
          w_gnt_rd   = !w_gnt_wr;
          w_state_nx = w_gnt_wr ? S_WRITE : S_ISSUE;
        end
      end
      S_ISSUE:   if (w_burst_end) w_state_nx = S_DRAIN;
      S_DRAIN:   if (w_drain_end) w_state_nx = S_IDLE;
      S_WRITE:   w_state_nx = S_IDLE;
`ifdef JTPANG_BA_REFRESH_EN
      S_REFRESH: if (w_ref_done) w_state_nx = S_IDLE;
`endif
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Stage 0: grant, address issue and write strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack       <= '0;
      r_dst       <= '0;
      r_dok       <= '0;
      r_rdy       <= '0;
      r_own_oh    <= '0;
      r_rr        <= '0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_din   <= '0;
      r_mem_din_m <= '0;
      r_data_read <= '0;
    end else begin
      r_ack <= '0;
      r_dst <= '0;
      r_dok <= '0;
      r_rdy <= '0;
      if (w_gnt_rd || w_gnt_wr) begin
        r_ack      <= w_gnt_oh;
        r_own_oh   <= w_gnt_oh;
        r_mem_addr <= w_gnt_addr;
        r_cnt      <= '0;
        r_mem_rd   <= w_gnt_rd;
        r_mem_we   <= w_gnt_wr;
        if (!w_gnt_prog) r_rr <= w_bank_sel + 2'd1;
        if (w_gnt_wr) begin
          r_mem_din   <= w_gnt_din;
          r_mem_din_m <= w_gnt_mask;
        end
      end
      if (r_state == S_ISSUE) begin
        if (w_burst_end) begin
          r_mem_rd <= 1'b0;
        end else begin
          r_mem_addr[AW-1:0] <= r_mem_addr[AW-1:0] + AW'(1);
          r_cnt              <= r_cnt + CW'(1);
        end
      end
      if (r_state == S_WRITE) begin
        r_mem_we <= 1'b0;
        r_rdy    <= r_own_oh;
      end
      // Stage LAT: returned word registered together with its strobes.
      if (r_vld_p[LAT-1]) begin
        r_data_read <= mem_dout;
        r_dok       <= r_own_oh;
        if (r_fst_p[LAT-1]) r_dst <= r_own_oh;
        if (r_lst_p[LAT-1]) r_rdy <= r_own_oh;
      end
    end
  end

  // Stages 1..LAT: read-valid tracking matching the memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p <= '0;
      r_fst_p <= '0;
      r_lst_p <= '0;
    end else begin
      r_vld_p[0] <= r_mem_rd;
      r_fst_p[0] <= r_mem_rd && (r_cnt == '0);
      r_lst_p[0] <= r_mem_rd && w_burst_end;
      for (int i = 1; i < LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_fst_p[i] <= r_fst_p[i-1];
        r_lst_p[i] <= r_lst_p[i-1];
      end
    end
  end

  assign ba_ack    = r_ack[3:0];
  assign ba_dst    = r_dst[3:0];
  assign ba_dok    = r_dok[3:0];
  assign ba_rdy    = r_rdy[3:0];
  assign prog_ack  = r_ack[4];
  assign prog_dst  = r_dst[4];
  assign prog_dok  = r_dok[4];
  assign prog_rdy  = r_rdy[4];
  assign data_read = r_data_read;
  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_we    = r_mem_we;
  assign mem_din   = r_mem_din;
  assign mem_din_m = r_mem_din_m;

endmodule

// File: tb/tb_jtpang_ba_resp.sv
// Directed bench for jtpang_ba_resp with a latency-matched memory model (word = addr[15:0]^C3C3).
module tb_jtpang_ba_resp;
  localparam int AW    = 22;
  localparam int BURST = 2;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr, prog_addr;
  logic [3:0]    ba_rd;
  logic          ba_wr;
  logic [15:0]   ba0_din, prog_data;
  logic [1:0]    ba0_din_m, prog_ba, prog_mask;
  logic          prog_we, prog_rd;
  logic [3:0]    ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0]   data_read;
  logic          prog_ack, prog_dst, prog_dok, prog_rdy;
  logic [AW+1:0] mem_addr;
  logic          mem_rd, mem_we;
  logic [15:0]   mem_din, mem_dout;
  logic [1:0]    mem_din_m;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_ovl = 0;

  always #5 clk = ~clk;

  jtpang_ba_resp #(.AW(AW), .BURST(BURST), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .data_read(data_read),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_rd(prog_rd),
    .prog_ack(prog_ack), .prog_dst(prog_dst), .prog_dok(prog_dok), .prog_rdy(prog_rdy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_din(mem_din), .mem_din_m(mem_din_m), .mem_dout(mem_dout)
  );

  // Memory model: data for the address presented in cycle c appears in cycle c+LAT.
  logic [AW+1:0] tb_pa [LAT];
  always @(posedge clk) begin
    tb_pa[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) tb_pa[i] <= tb_pa[i-1];
  end
  assign mem_dout = tb_pa[LAT-1][15:0] ^ 16'hC3C3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if ($countones({prog_dok, ba_dok}) > 1) n_ovl++;
  endtask

  task automatic do_reset();
    rst = 1'b1; ba_rd = '0; ba_wr = 1'b0; prog_we = 1'b0; prog_rd = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (ba_ack == 4'b0 && !prog_ack && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_gnt_seen"}, 32'((ba_ack != 4'b0) || prog_ack), 32'd1);
  endtask

  function automatic logic any_out();
    return (|{ba_ack, ba_dst, ba_dok, ba_rdy, prog_ack, prog_dst, prog_dok, prog_rdy,
              mem_rd, mem_we, mem_addr, mem_din, mem_din_m, data_read});
  endfunction

  // Called in grant cycle T; walks the burst through to T+6.
  task automatic read_seq(input string tag, input logic [4:0] oh, input logic [AW+1:0] a0,
                          input logic [AW+1:0] a1, input logic [15:0] d0, input logic [15:0] d1);
    chk({tag, "_ack"}, 32'({prog_ack, ba_ack}), 32'(oh));
    chk({tag, "_rd0"}, 32'({mem_rd, mem_we}), 32'b10);
    chk({tag, "_addr0"}, 32'(mem_addr), 32'(a0));
    ba_rd = ba_rd & ~oh[3:0];
    prog_rd = 1'b0;
    tick();
    chk({tag, "_rd1"}, 32'({mem_rd, prog_ack, ba_ack}), 32'b1_0_0000);
    chk({tag, "_addr1"}, 32'(mem_addr), 32'(a1));
    tick();
    chk({tag, "_rd_end"}, 32'(mem_rd), 32'd0);
    tick();
    chk({tag, "_early_dok"}, 32'({prog_dok, ba_dok}), 32'd0);
    tick();
    chk({tag, "_dok0"}, 32'({prog_dok, ba_dok}), 32'(oh));
    chk({tag, "_dst0"}, 32'({prog_dst, ba_dst, prog_rdy, ba_rdy}), 32'({oh, 5'b0}));
    chk({tag, "_data0"}, 32'(data_read), 32'(d0));
    tick();
    chk({tag, "_dok1"}, 32'({prog_dok, ba_dok}), 32'(oh));
    chk({tag, "_rdy1"}, 32'({prog_dst, ba_dst, prog_rdy, ba_rdy}), 32'({5'b0, oh}));
    chk({tag, "_data1"}, 32'(data_read), 32'(d1));
    tick();
    chk({tag, "_dok_off"}, 32'({prog_dok, ba_dok}), 32'd0);
    chk({tag, "_data_hold"}, 32'(data_read), 32'(d1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] e;
    int g_last, n_seen;
    ba0_addr = '0; ba1_addr = '0; ba2_addr = 22'h2; ba3_addr = 22'h3; prog_addr = '0;
    ba_rd = '0; ba_wr = 1'b0; ba0_din = '0; ba0_din_m = '0;
    prog_ba = '0; prog_data = '0; prog_mask = '0; prog_we = 1'b0; prog_rd = 1'b0;
    g_last = 0;

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outs", 32'(any_out()), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_outs", 32'(any_out()), 32'd0);

    // Single bank-1 read.
    ba1_addr = 22'h100; ba_rd = 4'b0010;
    wait_grant("t1");
    read_seq("t1", 5'b00010, 24'h400100, 24'h400101, 16'hC2C3, 16'hC2C2);

    // All banks requesting: round robin 0,1,2,3,0 at 6-cycle spacing.
    do_reset();
    ba_rd = 4'b1111; n_ovl = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr");
      e = 5'b00001 << (k % 4);
      chk("rr_ack", 32'({prog_ack, ba_ack}), 32'(e));
      if (k > 0) chk("rr_gap", 32'(cyc - g_last), 32'd6);
      g_last = cyc;
      tick();
    end
    ba_rd = '0;
    repeat (8) tick();
    chk("dok_overlap", 32'(n_ovl), 32'd0);

    // Programming write beats bank 0; bank 0 read follows two cycles later.
    do_reset();
    ba0_addr = '0; ba_rd = 4'b0001;
    prog_ba = 2'd2; prog_addr = 22'h5; prog_data = 16'hA55A; prog_mask = 2'b01; prog_we = 1'b1;
    prog_rd = 1'b1;
    wait_grant("t3");
    chk("t3_ack", 32'({prog_ack, ba_ack}), 32'b10000);
    chk("t3_we", 32'({mem_we, mem_rd}), 32'b10);
    chk("t3_addr", 32'(mem_addr), 32'h800005);
    chk("t3_din", 32'({mem_din, mem_din_m}), 32'({16'hA55A, 2'b01}));
    prog_we = 1'b0; prog_rd = 1'b0;
    tick();
    chk("t3_rdy", 32'({prog_rdy, prog_dst, prog_dok, mem_we}), 32'b1000);
    tick();
    read_seq("t3b", 5'b00001, 24'h000000, 24'h000001, 16'hC3C3, 16'hC3C2);

    // Word address wraps inside bank 1.
    ba1_addr = 22'h3FFFFF; ba_rd = 4'b0010;
    wait_grant("t4");
    read_seq("t4", 5'b00010, 24'h7FFFFF, 24'h400000, 16'h3C3C, 16'hC3C3);

    // Bank 0 write with mask.
    ba0_addr = 22'h1234; ba0_din = 16'hBEEF; ba0_din_m = 2'b10; ba_wr = 1'b1; ba_rd = 4'b0001;
    wait_grant("t5");
    chk("t5_ack", 32'({prog_ack, ba_ack}), 32'b00001);
    chk("t5_we", 32'({mem_we, mem_rd}), 32'b10);
    chk("t5_addr", 32'(mem_addr), 32'h001234);
    chk("t5_din", 32'({mem_din, mem_din_m}), 32'({16'hBEEF, 2'b10}));
    ba_rd = '0; ba_wr = 1'b0;
    tick();
    chk("t5_rdy", 32'({ba_rdy, ba_dst, ba_dok, mem_we}), 32'({4'b0001, 4'b0, 4'b0, 1'b0}));
    tick();

    // Programming read of bank 3.
    prog_ba = 2'd3; prog_addr = 22'h10; prog_rd = 1'b1;
    wait_grant("t6");
    read_seq("t6", 5'b10000, 24'hC00010, 24'hC00011, 16'hC3D3, 16'hC3D2);

    // Reset during a read discards it; a fresh request then completes.
    ba2_addr = 22'h20; ba_rd = 4'b0100;
    wait_grant("t7");
    chk("t7_ack", 32'({prog_ack, ba_ack}), 32'b00100);
    ba_rd = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t7_rst_outs", 32'(any_out()), 32'd0);
    rst = 1'b0;
    n_seen = 0;
    repeat (8) begin
      tick();
      if (|{prog_dok, ba_dok, prog_rdy, ba_rdy, prog_dst, ba_dst}) n_seen++;
    end
    chk("t7_no_strobe", 32'(n_seen), 32'd0);
    ba3_addr = 22'h7; ba_rd = 4'b1000;
    wait_grant("t8");
    read_seq("t8", 5'b01000, 24'hC00007, 24'hC00008, 16'hC3C4, 16'hC3CB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
